// File: rtl/keccak_round_ctrl.sv
// Round sequencer for the Keccak-f[1600] datapath: load, NUM_ROUNDS single-cycle
// rounds, write-back, then a done level and a sticky interrupt.
module keccak_round_ctrl #(
  parameter int NUM_ROUNDS = 24,
  parameter int CNT_W      = $clog2(NUM_ROUNDS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             intr_en_i,
  input  logic             intr_clr_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             load_o,
  output logic             round_en_o,
  output logic [CNT_W-1:0] round_idx_o,
  output logic             out_we_o,
  output logic             intr_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ROUND = 2'd2,
    WB    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_ROUNDS - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             done_reg, done_next;
  logic             intr_reg, intr_next;
  logic             wb_complete;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
      intr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
      intr_reg  <= intr_next;
    end
  end

  // An abort during WB still lets that cycle's write-back happen, but it is not a completion.
  assign wb_complete = (state_reg == WB) && !abort_i;

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (start_i) state_next = LOAD;
      LOAD:    state_next = abort_i ? IDLE : ROUND;
      ROUND: begin
        if (abort_i)                   state_next = IDLE;
        else if (cnt_reg == LAST_IDX)  state_next = WB;
      end
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Counter only advances while remaining in ROUND, so it saturates at LAST_IDX.
    cnt_next = '0;
    if (state_reg == ROUND && state_next == ROUND) cnt_next = cnt_reg + CNT_W'(1);

    done_next = done_reg;
    if (state_reg == IDLE && start_i) done_next = 1'b0;
    if (wb_complete)                  done_next = 1'b1;

    intr_next = intr_reg;
    if (intr_clr_i)                   intr_next = 1'b0;
    if (wb_complete && intr_en_i)     intr_next = 1'b1;
  end

  always_comb begin
    busy_o      = (state_reg != IDLE);
    load_o      = (state_reg == LOAD);
    round_en_o  = (state_reg == ROUND);
    out_we_o    = (state_reg == WB);
    round_idx_o = (state_reg == ROUND) ? cnt_reg : '0;
    done_o      = done_reg;
    intr_o      = intr_reg;
  end

endmodule

// File: tb/tb_keccak_round_ctrl.sv
// Directed bench for keccak_round_ctrl: expected output vectors come from a
// cycle-count model of one permutation run.
module tb_keccak_round_ctrl;

  localparam int N = 24;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort, intr_en, intr_clr;
  logic       busy, done, load, round_en, out_we, intr;
  logic [4:0] idx;

  int vec_cnt = 0;
  int err_cnt = 0;

  keccak_round_ctrl #(.NUM_ROUNDS(N)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .abort_i    (abort),
    .intr_en_i  (intr_en),
    .intr_clr_i (intr_clr),
    .busy_o     (busy),
    .done_o     (done),
    .load_o     (load),
    .round_en_o (round_en),
    .round_idx_o(idx),
    .out_we_o   (out_we),
    .intr_o     (intr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {busy, done, load, round_en, idx[4:0], out_we, intr}
  function automatic logic [10:0] obs();
    return {busy, done, load, round_en, idx, out_we, intr};
  endfunction

  // Expected outputs in cycle c after the start edge (c = 1 .. N+3).
  function automatic logic [10:0] exp_run(input int c, input logic intr_before,
                                          input logic intr_after);
    logic       e_busy, e_done, e_load, e_ren, e_owe, e_intr;
    logic [4:0] e_idx;
    e_busy = (c <= N + 2);
    e_done = (c == N + 3);
    e_load = (c == 1);
    e_ren  = (c >= 2) && (c <= N + 1);
    e_idx  = e_ren ? 5'(c - 2) : 5'd0;
    e_owe  = (c == N + 2);
    e_intr = (c == N + 3) ? intr_after : intr_before;
    return {e_busy, e_done, e_load, e_ren, e_idx, e_owe, e_intr};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start = 0; abort = 0; intr_en = 0; intr_clr = 0;
    tick(); tick();
    vec_cnt++;
    if (obs() !== 11'd0) begin
      err_cnt++;
      $display("FAIL reset_held got=%b exp=%b", obs(), 11'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vec_cnt++;
      if (obs() !== 11'd0) begin
        err_cnt++;
        $display("FAIL reset_idle[%0d] got=%b exp=%b", i, obs(), 11'd0);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    intr_en = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= N + 3; c++) begin
      vec_cnt++;
      if (obs() !== exp_run(c, 1'b0, 1'b1)) begin
        err_cnt++;
        $display("FAIL basic c=%0d got=%b exp=%b", c, obs(), exp_run(c, 1'b0, 1'b1));
      end
      if (c < N + 3) tick();
    end
    $display("test_basic done");
  endtask

  // Start while done=1 (done must drop in LOAD); second start at idx 10 must be ignored.
  // Enable is off for this run, so the interrupt left pending by the previous run must persist.
  task automatic test_restart();
    int we_seen = 0;
    intr_en = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= N + 3; c++) begin
      vec_cnt++;
      if (obs() !== exp_run(c, 1'b1, 1'b1)) begin
        err_cnt++;
        $display("FAIL restart c=%0d got=%b exp=%b", c, obs(), exp_run(c, 1'b1, 1'b1));
      end
      if (out_we) we_seen++;
      if (c < N + 3) begin
        if (c == 12) start = 1'b1;
        tick();
        start = 1'b0;
      end
    end
    vec_cnt++;
    if (we_seen !== 1) begin
      err_cnt++;
      $display("FAIL restart_we_count got=%0d exp=%0d", we_seen, 1);
    end
    $display("test_restart done");
  endtask

  task automatic test_intr();
    // Pending interrupt cleared by a pulse; done untouched.
    intr_clr = 1'b1; tick(); intr_clr = 1'b0;
    vec_cnt++;
    if ({done, intr} !== 2'b10) begin
      err_cnt++;
      $display("FAIL intr_clear got=%b exp=%b", {done, intr}, 2'b10);
    end
    // Disabled run: done without interrupt.
    intr_en = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= N + 3; c++) begin
      vec_cnt++;
      if (obs() !== exp_run(c, 1'b0, 1'b0)) begin
        err_cnt++;
        $display("FAIL intr_disabled c=%0d got=%b exp=%b", c, obs(), exp_run(c, 1'b0, 1'b0));
      end
      if (c < N + 3) tick();
    end
    // Enabled run with a clear coinciding with the set: set wins.
    intr_en = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= N + 3; c++) begin
      vec_cnt++;
      if (obs() !== exp_run(c, 1'b0, 1'b1)) begin
        err_cnt++;
        $display("FAIL intr_set_wins c=%0d got=%b exp=%b", c, obs(), exp_run(c, 1'b0, 1'b1));
      end
      if (c < N + 3) begin
        if (c == N + 2) intr_clr = 1'b1;
        tick();
        intr_clr = 1'b0;
      end
    end
    tick(); tick();
    vec_cnt++;
    if (intr !== 1'b1) begin
      err_cnt++;
      $display("FAIL intr_sticky got=%b exp=%b", intr, 1'b1);
    end
    intr_clr = 1'b1; tick(); intr_clr = 1'b0;
    vec_cnt++;
    if ({done, intr} !== 2'b10) begin
      err_cnt++;
      $display("FAIL intr_late_clear got=%b exp=%b", {done, intr}, 2'b10);
    end
    $display("test_intr done");
  endtask

  task automatic test_abort();
    int we_seen = 0;
    intr_en = 1'b1;
    // Abort at idx 5 (cycle 7).
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      vec_cnt++;
      if (obs() !== exp_run(c, 1'b0, 1'b0)) begin
        err_cnt++;
        $display("FAIL abort_pre c=%0d got=%b exp=%b", c, obs(), exp_run(c, 1'b0, 1'b0));
      end
      if (c == 7) abort = 1'b1;
      tick();
      abort = 1'b0;
    end
    for (int i = 0; i < 30; i++) begin
      vec_cnt++;
      if (obs() !== 11'd0) begin
        err_cnt++;
        $display("FAIL abort_idle[%0d] got=%b exp=%b", i, obs(), 11'd0);
      end
      if (out_we) we_seen++;
      tick();
    end
    vec_cnt++;
    if (we_seen !== 0) begin
      err_cnt++;
      $display("FAIL abort_we_count got=%0d exp=%0d", we_seen, 0);
    end
    // Start with abort in IDLE is accepted; abort during WB keeps out_we but suppresses done/intr.
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    for (int c = 1; c <= N + 2; c++) begin
      vec_cnt++;
      if (obs() !== exp_run(c, 1'b0, 1'b0)) begin
        err_cnt++;
        $display("FAIL abort_wb c=%0d got=%b exp=%b", c, obs(), exp_run(c, 1'b0, 1'b0));
      end
      if (c == N + 2) abort = 1'b1;
      tick();
      abort = 1'b0;
    end
    vec_cnt++;
    if (obs() !== 11'd0) begin
      err_cnt++;
      $display("FAIL abort_wb_after got=%b exp=%b", obs(), 11'd0);
    end
    $display("test_abort done");
  endtask

  task automatic test_async_reset();
    intr_en = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c < 14; c++) tick();
    vec_cnt++;
    if (obs() !== exp_run(14, 1'b0, 1'b0)) begin
      err_cnt++;
      $display("FAIL async_pre got=%b exp=%b", obs(), exp_run(14, 1'b0, 1'b0));
    end
    #2 rst_n = 1'b0;
    #1;
    vec_cnt++;
    if (obs() !== 11'd0) begin
      err_cnt++;
      $display("FAIL async_reset got=%b exp=%b", obs(), 11'd0);
    end
    tick();
    rst_n = 1'b1;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= N + 3; c++) begin
      vec_cnt++;
      if (obs() !== exp_run(c, 1'b0, 1'b1)) begin
        err_cnt++;
        $display("FAIL async_fresh c=%0d got=%b exp=%b", c, obs(), exp_run(c, 1'b0, 1'b1));
      end
      if (c < N + 3) tick();
    end
    $display("test_async_reset done");
  endtask

  task automatic test_back_to_back();
    intr_en = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= N + 3; c++) begin
      vec_cnt++;
      if (obs() !== exp_run(c, 1'b1, 1'b1)) begin
        err_cnt++;
        $display("FAIL b2b_first c=%0d got=%b exp=%b", c, obs(), exp_run(c, 1'b1, 1'b1));
      end
      if (c < N + 3) tick();
    end
    // Start issued in the cycle done rises.
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= N + 3; c++) begin
      vec_cnt++;
      if (obs() !== exp_run(c, 1'b1, 1'b1)) begin
        err_cnt++;
        $display("FAIL b2b_second c=%0d got=%b exp=%b", c, obs(), exp_run(c, 1'b1, 1'b1));
      end
      if (c < N + 3) tick();
    end
    $display("test_back_to_back done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_restart();
    test_intr();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
